// File: rtl/vec_pkg.sv
// Shared widths, types and the round/saturate helper for the vec_mul accumulator stage.
// Purely combinational helpers. No latency and no handshake.
package vec_pkg;

    localparam int C          = 9;
    localparam int W_X        = 8;
    localparam int W_K        = 8;
    localparam int MAX_CHUNKS = 16;
    localparam int W_OUT      = 8;

    function automatic int calc_w_y(input int c, input int wx, input int wk);
        return wx + wk + $clog2(c);
    endfunction

    function automatic int calc_w_acc(input int wy, input int max_chunks);
        return wy + $clog2(max_chunks);
    endfunction

    localparam int W_Y   = calc_w_y(C, W_X, W_K);
    localparam int W_ACC = calc_w_acc(W_Y, MAX_CHUNKS);
    localparam int W_N   = $clog2(MAX_CHUNKS + 1);
    localparam int W_SH  = $clog2(W_ACC);

    typedef logic signed [W_Y-1:0]   y_t;
    typedef logic signed [W_ACC-1:0] acc_t;
    typedef logic signed [W_OUT-1:0] out_t;
    typedef logic        [W_N-1:0]   nch_t;
    typedef logic        [W_SH-1:0]  sh_t;

    // Saturation bounds held at the one-bit-wider rounding width.
    localparam logic signed [W_ACC:0] SAT_HI = (W_ACC+1)'((2 ** (W_OUT - 1)) - 1);
    localparam logic signed [W_ACC:0] SAT_LO = ~SAT_HI;

    // Round half up, arithmetic shift, optional clamp of negatives, then saturate.
    // The extra bit keeps acc + 2^(s-1) from wrapping at the top of the range.
    function automatic out_t round_sat(input acc_t a, input sh_t s, input logic relu);
        logic signed [W_ACC:0] t;
        logic signed [W_ACC:0] bias;
        bias = '0;
        if (s != '0)
            bias[s - sh_t'(1)] = 1'b1;
        t = $signed({a[W_ACC-1], a}) + bias;
        t = t >>> s;
        if (relu && (t < 0))
            t = '0;
        if (t > SAT_HI)
            return out_t'(SAT_HI);
        if (t < SAT_LO)
            return out_t'(SAT_LO);
        return out_t'(t);
    endfunction

endpackage

// File: rtl/vec_round_sat.sv
// Quantises an accumulated sum to W_OUT bits. Negative clamp when VEC_ACC_QUANT_RELU_EN is defined.
// Combinational, zero latency. No handshake.
module vec_round_sat
    import vec_pkg::*;
(
    input  logic signed [W_ACC-1:0] acc,
    input  logic        [W_SH-1:0]  shift,
    output logic signed [W_OUT-1:0] out_data
);

`ifdef VEC_ACC_QUANT_RELU_EN
    localparam logic RELU = 1'b1;
`else
    localparam logic RELU = 1'b0;
`endif

    assign out_data = round_sat(acc, shift, RELU);

endmodule

// File: rtl/vec_acc_quant.sv
// Accumulates num_chunks partial dot products, then rounds, shifts and saturates (RELU via VEC_ACC_QUANT_RELU_EN).
// Latency: result valid one cycle after the last beat of a group; one result per cycle when N=1.
// Backpressure: a held result drops pe_enable, which freezes vec_mul and this stage's state.
module vec_acc_quant
    import vec_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [W_Y-1:0]   y,
    input  logic        [W_N-1:0]   num_chunks,
    input  logic        [W_SH-1:0]  shift,
    output logic                    pe_enable,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [W_OUT-1:0] out_data,
    output logic                    busy
);

    acc_t acc;
    nch_t cnt;
    nch_t n_lat;
    sh_t  s_lat;

    logic accept;
    logic first;
    logic last;
    nch_t cnt_inc;
    nch_t n_eff;
    sh_t  s_eff;
    acc_t acc_next;
    out_t quant;

    assign pe_enable = !(out_valid && !out_ready);
    assign accept    = in_valid && pe_enable;
    assign first     = (cnt == '0);
    assign cnt_inc   = cnt + nch_t'(1);
    assign busy      = !first;

    // Group parameters come straight from the ports on the first beat, from the latches after that.
    always_comb begin
        n_eff = n_lat;
        s_eff = s_lat;
        if (first) begin
            n_eff = (num_chunks == '0) ? nch_t'(1) : num_chunks;
            s_eff = (shift > sh_t'(W_ACC - 1)) ? sh_t'(W_ACC - 1) : shift;
        end
    end

    assign acc_next = (first ? acc_t'(0) : acc) + acc_t'(y);
    assign last     = (cnt_inc == n_eff);

    vec_round_sat u_round_sat (
        .acc      (acc_next),
        .shift    (s_eff),
        .out_data (quant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            n_lat     <= '0;
            s_lat     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                if (first) begin
                    n_lat <= n_eff;
                    s_lat <= s_eff;
                end
                // A last beat in the same cycle as a transfer overrides the clear above.
                if (last) begin
                    cnt       <= '0;
                    out_data  <= quant;
                    out_valid <= 1'b1;
                end else begin
                    cnt <= cnt_inc;
                    acc <= acc_next;
                end
            end
        end
    end

endmodule
